// File: rtl/fifo_fast_blk_w_ctrl_signals_pkg.sv
// Shared definitions and helpers for the fast-producer / slow-consumer lane buffer.
// Provides MODE_WORK, DATA_WIDTH_BUFF_SO_SEG and NUM_SEG_PER_STG if no project-wide header has done so.
`ifndef MODE_WORK
`define MODE_WORK 1'b1
`endif
`ifndef DATA_WIDTH_BUFF_SO_SEG
`define DATA_WIDTH_BUFF_SO_SEG 16
`endif
`ifndef NUM_SEG_PER_STG
`define NUM_SEG_PER_STG 4
`endif

package fifo_fast_blk_w_ctrl_signals_pkg;

  localparam int unsigned MIN_DIV_RATIO = 2;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned mod_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_fast_blk_w_ctrl_signals_fifo_fast_blk.sv
// Single-lane buffer: synchronous write, registered read, occupancy count.
// Read data appears the cycle after rd_vld; callers must not write when full or read when empty.
module fifo_fast_blk #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic [ADDR_W:0]       count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  // Storage is deliberately left unreset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else begin
      if (wr_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_vld) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_dat <= mem[rd_ptr];
      end
      case ({wr_vld, rd_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_fast_blk_w_ctrl_signals.sv
// Per-lane FIFOs bridging a fast producer to a consumer ticking every DIV_RATIO cycles; pop data lands one cycle after commit.
// A commit is held off while any requested lane is empty; define FAST_BLK_ALMOST_FULL_EN for the early not-full output.
module fifo_fast_blk_w_ctrl_signals
  import fifo_fast_blk_w_ctrl_signals_pkg::*;
#(
  parameter int DATA_WIDTH              = `DATA_WIDTH_BUFF_SO_SEG,
  parameter int NUM_FAST_BLK            = `NUM_SEG_PER_STG,
  parameter int FAST_BLK_BUFF_SIZE      = 8,
  parameter int BITS_FAST_BLK_BUFF_ADDR = 3,
  parameter int DIV_RATIO               = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    unit_en,
  input  logic                                    mode,
  input  logic [NUM_FAST_BLK-1:0]                 wr_en_fast,
  input  logic [NUM_FAST_BLK-1:0][DATA_WIDTH-1:0] data_in_fast,
  input  logic [NUM_FAST_BLK-1:0]                 en_outtake_slow,
  input  logic                                    out_q_wr_ready_slow,
  output logic [NUM_FAST_BLK-1:0]                 in_fifo_wr_ready_fast,
  output logic [NUM_FAST_BLK-1:0]                 in_fifo_wr_ready_fast_adv,
  output logic                                    slow_tick,
  output logic                                    blk_en_slow,
  output logic [NUM_FAST_BLK-1:0][DATA_WIDTH-1:0] data_out_slow,
  output logic [NUM_FAST_BLK-1:0]                 data_out_valid_slow
);

  localparam int DIV_W = mod_cnt_width(DIV_RATIO);
  localparam int CNT_W = BITS_FAST_BLK_BUFF_ADDR + 1;

  logic [DIV_W-1:0]                   div_cnt;
  logic                               mode_reg;
  logic                               work_reg;
  logic                               halt;
  logic [NUM_FAST_BLK-1:0]            empty;
  logic [NUM_FAST_BLK-1:0]            wr_acc;
  logic [NUM_FAST_BLK-1:0]            pop;
  logic [NUM_FAST_BLK-1:0][CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      mode_reg <= 1'b0;
    end else begin
      mode_reg <= mode;
      div_cnt  <= (div_cnt == DIV_W'(DIV_RATIO - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  assign work_reg    = (mode_reg == `MODE_WORK);
  assign slow_tick   = ~rst & (div_cnt == DIV_W'(DIV_RATIO - 1));
  assign halt        = work_reg & |(en_outtake_slow & empty);
  assign blk_en_slow = slow_tick & (mode == `MODE_WORK) & unit_en & ~halt & out_q_wr_ready_slow;

  for (genvar i = 0; i < NUM_FAST_BLK; i++) begin : g_lane
    assign in_fifo_wr_ready_fast[i] = (count[i] < CNT_W'(FAST_BLK_BUFF_SIZE));
    assign empty[i]                 = (count[i] == '0);
    assign wr_acc[i]                = work_reg & wr_en_fast[i] & in_fifo_wr_ready_fast[i];
    // The empty guard covers the mode_reg lag right after entering work mode.
    assign pop[i]                   = blk_en_slow & en_outtake_slow[i] & ~empty[i];

`ifdef FAST_BLK_ALMOST_FULL_EN
    assign in_fifo_wr_ready_fast_adv[i] = (count[i] < CNT_W'(FAST_BLK_BUFF_SIZE - 1));
`else
    assign in_fifo_wr_ready_fast_adv[i] = in_fifo_wr_ready_fast[i];
`endif

    fifo_fast_blk #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FAST_BLK_BUFF_SIZE),
      .ADDR_W     (BITS_FAST_BLK_BUFF_ADDR)
    ) u_fifo_fast_blk (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (wr_acc[i]),
      .wr_dat (data_in_fast[i]),
      .rd_vld (pop[i]),
      .rd_dat (data_out_slow[i]),
      .count  (count[i])
    );
  end

  // Valid reflects only the most recent commit; it holds between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid_slow <= '0;
    end else if (blk_en_slow) begin
      data_out_valid_slow <= pop;
    end
  end

endmodule

// File: tb/tb_fifo_fast_blk_w_ctrl_signals.sv
// Scoreboard bench: accepted writes are queued per lane, popped on commits, and compared against DUT outputs each cycle.
module tb_fifo_fast_blk_w_ctrl_signals;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int SIZE = 8;
  localparam int DIV  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                unit_en;
  logic                mode;
  logic [N-1:0]        wr_en_fast;
  logic [N-1:0][W-1:0] data_in_fast;
  logic [N-1:0]        en_outtake_slow;
  logic                out_q_wr_ready_slow;
  logic [N-1:0]        in_fifo_wr_ready_fast;
  logic [N-1:0]        in_fifo_wr_ready_fast_adv;
  logic                slow_tick;
  logic                blk_en_slow;
  logic [N-1:0][W-1:0] data_out_slow;
  logic [N-1:0]        data_out_valid_slow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_fast_blk_w_ctrl_signals #(
    .DATA_WIDTH              (W),
    .NUM_FAST_BLK            (N),
    .FAST_BLK_BUFF_SIZE      (SIZE),
    .BITS_FAST_BLK_BUFF_ADDR (3),
    .DIV_RATIO               (DIV)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .unit_en                   (unit_en),
    .mode                      (mode),
    .wr_en_fast                (wr_en_fast),
    .data_in_fast              (data_in_fast),
    .en_outtake_slow           (en_outtake_slow),
    .out_q_wr_ready_slow       (out_q_wr_ready_slow),
    .in_fifo_wr_ready_fast     (in_fifo_wr_ready_fast),
    .in_fifo_wr_ready_fast_adv (in_fifo_wr_ready_fast_adv),
    .slow_tick                 (slow_tick),
    .blk_en_slow               (blk_en_slow),
    .data_out_slow             (data_out_slow),
    .data_out_valid_slow       (data_out_valid_slow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference state: per-lane expected-data queues plus the slow-side output registers.
  logic [W-1:0]        sb_q [N][$];
  int                  m_div      = 0;
  logic                m_mode_reg = 1'b0;
  logic [N-1:0][W-1:0] m_dout     = '0;
  logic [N-1:0]        m_vld      = '0;

  always @(negedge clk) begin : model
    logic         tick;
    logic         halt;
    logic         blk;
    logic [N-1:0] empty_v;
    logic [N-1:0] rdy_v;
    logic [N-1:0] adv_v;
    logic [N-1:0] pop_v;
    logic [N-1:0] wr_v;

    for (int i = 0; i < N; i++) begin
      empty_v[i] = (sb_q[i].size() == 0);
      rdy_v[i]   = (sb_q[i].size() < SIZE);
`ifdef FAST_BLK_ALMOST_FULL_EN
      adv_v[i]   = (sb_q[i].size() < SIZE - 1);
`else
      adv_v[i]   = rdy_v[i];
`endif
    end
    tick = !rst && (m_div == DIV - 1);
    halt = m_mode_reg && |(en_outtake_slow & empty_v);
    blk  = tick && mode && unit_en && !halt && out_q_wr_ready_slow;

    check("slow_tick",   64'(slow_tick),                 64'(tick));
    check("blk_en_slow", 64'(blk_en_slow),               64'(blk));
    check("wr_ready",    64'(in_fifo_wr_ready_fast),     64'(rdy_v));
    check("wr_ready_adv", 64'(in_fifo_wr_ready_fast_adv), 64'(adv_v));
    check("out_valid",   64'(data_out_valid_slow),       64'(m_vld));
    check("out_data",    64'(data_out_slow),             64'(m_dout));

    if (rst) begin
      m_div      = 0;
      m_mode_reg = 1'b0;
      m_dout     = '0;
      m_vld      = '0;
      for (int i = 0; i < N; i++) sb_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        wr_v[i]  = m_mode_reg && wr_en_fast[i] && rdy_v[i];
        pop_v[i] = blk && en_outtake_slow[i] && !empty_v[i];
      end
      for (int i = 0; i < N; i++) begin
        if (pop_v[i]) m_dout[i] = sb_q[i].pop_front();
        if (wr_v[i])  sb_q[i].push_back(data_in_fast[i]);
        if (blk)      m_vld[i] = pop_v[i];
      end
      m_div      = (m_div == DIV - 1) ? 0 : m_div + 1;
      m_mode_reg = mode;
    end
  end

  initial begin : stim
    logic found;
    rst                 = 1'b1;
    unit_en             = 1'b1;
    mode                = 1'b1;
    wr_en_fast          = '0;
    data_in_fast        = '0;
    en_outtake_slow     = '0;
    out_q_wr_ready_slow = 1'b1;
    step(2);
    rst = 1'b0;

    // Cycle 0 after reset: everything idle and ready.
    @(negedge clk);
    check("rst_ready", 64'(in_fifo_wr_ready_fast), 64'hF);
    check("rst_valid", 64'(data_out_valid_slow),   64'h0);
    check("rst_data",  64'(data_out_slow),         64'h0);

    // Three writes on lane 0 in cycles 1..3 with outtake requested; commits at ticks 3, 7, 11.
    en_outtake_slow = 4'b0001;
    step(1);
    for (int k = 0; k < 3; k++) begin
      wr_en_fast      = 4'b0001;
      data_in_fast[0] = 16'hA000 + 16'(k);
      step(1);
    end
    wr_en_fast = '0;
    @(negedge clk);
    check("l0_first_valid", 64'(data_out_valid_slow[0]), 64'h1);
    check("l0_first_data",  64'(data_out_slow[0]),       64'hA000);
    step(8);
    @(negedge clk);
    check("l0_third_data",  64'(data_out_slow[0]),       64'hA002);
    en_outtake_slow = '0;

    // Fill lane 1 with nine writes; the ninth is dropped.
    for (int k = 0; k < 9; k++) begin
      wr_en_fast      = 4'b0010;
      data_in_fast[1] = 16'hB000 + 16'(k);
      step(1);
      if (k == 7) begin
        @(negedge clk);
        check("l1_full_ready", 64'(in_fifo_wr_ready_fast[1]), 64'h0);
      end
    end
    wr_en_fast = '0;
    @(negedge clk);
    check("l1_still_full", 64'(in_fifo_wr_ready_fast[1]), 64'h0);

    // Lane 2 empty while requested: no commit until it receives a word.
    en_outtake_slow = 4'b0110;
    repeat (8) begin
      @(negedge clk);
      check("halt_blk_en", 64'(blk_en_slow), 64'h0);
      step(1);
    end
    wr_en_fast      = 4'b0100;
    data_in_fast[2] = 16'hC000;
    step(1);
    wr_en_fast = '0;
    found      = 1'b0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (blk_en_slow) found = 1'b1;
      step(1);
    end
    check("halt_release", 64'(found), 64'h1);

    // Lane 1 kept at/near full while draining: write+pop collisions and pointer wrap.
    en_outtake_slow = 4'b0010;
    for (int k = 0; k < 48; k++) begin
      wr_en_fast      = 4'b0010;
      data_in_fast[1] = 16'hD000 + 16'(k);
      step(1);
    end
    wr_en_fast = '0;

    // Buffer words on lane 3, then reset mid-operation.
    en_outtake_slow = '0;
    for (int k = 0; k < 5; k++) begin
      wr_en_fast      = 4'b1000;
      data_in_fast[3] = 16'hE000 + 16'(k);
      step(1);
    end
    wr_en_fast = '0;
    rst        = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(in_fifo_wr_ready_fast), 64'hF);
    check("midrst_valid", 64'(data_out_valid_slow),   64'h0);
    step(1);

    // Randomised traffic with occasional mode, enable and downstream stalls.
    for (int k = 0; k < 400; k++) begin
      wr_en_fast          = 4'($urandom);
      data_in_fast        = {$urandom, $urandom};
      en_outtake_slow     = 4'($urandom);
      mode                = ($urandom_range(0, 15) != 0);
      unit_en             = ($urandom_range(0, 7) != 0);
      out_q_wr_ready_slow = ($urandom_range(0, 5) != 0);
      step(1);
    end
    wr_en_fast = '0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
